// File: rtl/dlx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dlx_pkg                                                |
// | Description : DLX opcode constants, IF/ID defaults and the decode    |
// |               control bundle shared by decoder and IF/ID stage.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
package dlx_pkg;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] c_OP_RTYPE = 6'h00;
  localparam logic [5:0] c_OP_J     = 6'h02;
  localparam logic [5:0] c_OP_JAL   = 6'h03;
  localparam logic [5:0] c_OP_BEQZ  = 6'h04;
  localparam logic [5:0] c_OP_BNEZ  = 6'h05;
  localparam logic [5:0] c_OP_JR    = 6'h12;
  localparam logic [5:0] c_OP_JALR  = 6'h13;
  localparam logic [5:0] c_OP_ANDI  = 6'h0c;
  localparam logic [5:0] c_OP_XORI  = 6'h0e;

  // Defaults for the IF/ID stage
  localparam logic [31:0] c_NOP_INSTR = 32'h0000_0000;
  localparam logic [4:0]  c_LINK_REG  = 5'd31;

  // Decode control bundle; rd_rs1/rd_rs2 flag which operands the
  // instruction actually reads (used only by the load-use interlock).
  typedef struct packed {
    logic beqz;
    logic bnez;
    logic jump;
    logic jump_reg;
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic rd_rs1;
    logic rd_rs2;
  } dec_ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == 6'h20) || (op == 6'h21) || (op == 6'h23) ||
           (op == 6'h24) || (op == 6'h25);
  endfunction

  function automatic logic is_store(input logic [5:0] op);
    return (op == 6'h28) || (op == 6'h29) || (op == 6'h2b);
  endfunction

  // I-type ALU ops that write rd: ADDI..LHI and shift/set-immediate group
  function automatic logic is_alu_imm(input logic [5:0] op);
    return ((op >= 6'h08) && (op <= 6'h0f)) || ((op >= 6'h14) && (op <= 6'h1d));
  endfunction

endpackage
`default_nettype wire

// File: rtl/dlx_decoder.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : dlx_decoder                                            |
// | Description : Purely combinational DLX decode: controls, register    |
// |               addresses, destination and extended immediate.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module dlx_decoder
  import dlx_pkg::*;
#(
  parameter int          XLEN     = 32,
  parameter logic [4:0]  LINK_REG = c_LINK_REG
) (
  input  logic [31:0]     i_instr,
  output dec_ctrl_t       o_ctrl,
  output logic [4:0]      o_rs1,
  output logic [4:0]      o_rs2,
  output logic [4:0]      o_rd,
  output logic [25:0]     o_value,
  output logic [XLEN-1:0] o_ext_imm
);

  logic [5:0] w_op;
  logic       w_writes;

  assign w_op    = i_instr[31:26];
  assign o_rs1   = i_instr[25:21];
  assign o_rs2   = i_instr[20:16];
  assign o_value = i_instr[25:0];

  // Logical immediates are zero-extended; everything else sign-extends.
  assign o_ext_imm = ((w_op >= c_OP_ANDI) && (w_op <= c_OP_XORI))
                   ? {{(XLEN-16){1'b0}}, i_instr[15:0]}
                   : {{(XLEN-16){i_instr[15]}}, i_instr[15:0]};

  // Opcode -> control bundle and destination register selection
  always_comb begin
    o_ctrl   = '0;
    o_rd     = i_instr[20:16];
    w_writes = 1'b0;
    case (w_op)
      c_OP_RTYPE: begin
        o_rd          = i_instr[15:11];
        w_writes      = 1'b1;
        o_ctrl.rd_rs1 = 1'b1;
        o_ctrl.rd_rs2 = 1'b1;
      end
      c_OP_J: begin
        o_ctrl.jump = 1'b1;
      end
      c_OP_JAL: begin
        o_ctrl.jump = 1'b1;
        o_rd        = LINK_REG;
        w_writes    = 1'b1;
      end
      c_OP_BEQZ: begin
        o_ctrl.beqz   = 1'b1;
        o_ctrl.rd_rs1 = 1'b1;
      end
      c_OP_BNEZ: begin
        o_ctrl.bnez   = 1'b1;
        o_ctrl.rd_rs1 = 1'b1;
      end
      c_OP_JR: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.jump_reg = 1'b1;
        o_ctrl.rd_rs1   = 1'b1;
      end
      c_OP_JALR: begin
        o_ctrl.jump     = 1'b1;
        o_ctrl.jump_reg = 1'b1;
        o_ctrl.rd_rs1   = 1'b1;
        o_rd            = LINK_REG;
        w_writes        = 1'b1;
      end
      default: begin
        o_ctrl.rd_rs1 = 1'b1;
        if (is_load(w_op)) begin
          o_ctrl.mem_read = 1'b1;
          w_writes        = 1'b1;
        end else if (is_store(w_op)) begin
          o_ctrl.mem_write = 1'b1;
          o_ctrl.rd_rs2    = 1'b1;
        end else if (is_alu_imm(w_op)) begin
          w_writes = 1'b1;
        end
      end
    endcase
    // Writes to r0 are discarded, so they are not reported as writes.
    o_ctrl.reg_write = w_writes && (o_rd != 5'd0);
  end

endmodule
`default_nettype wire

// File: rtl/if_id_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : if_id_decode                                           |
// | Description : IF/ID pipeline register with DLX decode, load-use      |
// |               interlock and wrong-path squash after a redirect.      |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module if_id_decode
  import dlx_pkg::*;
#(
  parameter int          XLEN      = 32,
  parameter logic [31:0] NOP_INSTR = c_NOP_INSTR,
  parameter logic [4:0]  LINK_REG  = c_LINK_REG
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [31:0]     if_instr,
  input  logic [XLEN-1:0] if_pc_plus4,
  input  logic            zero_flag,
  output logic            id_valid,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc_plus4,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  output logic [4:0]      rd_addr,
  output logic            beqz,
  output logic            bnez,
  output logic            jump,
  output logic            jump_reg,
  output logic [25:0]     value,
  output logic [XLEN-1:0] extended_imm,
  output logic            mem_read,
  output logic            mem_write,
  output logic            reg_write,
  output logic            pc_stall,
  output logic            ex_bubble
);

  logic            r_valid;
  logic [31:0]     r_instr;
  logic [XLEN-1:0] r_pc_plus4;
  logic            r_ex_load_valid;
  logic [4:0]      r_ex_load_rd;

  dec_ctrl_t       w_ctrl;
  logic            w_stall;
  logic            w_gate;
  logic            w_redirect;

  dlx_decoder #(
    .XLEN     (XLEN),
    .LINK_REG (LINK_REG)
  ) u_dec (
    .i_instr   (r_instr),
    .o_ctrl    (w_ctrl),
    .o_rs1     (rs1_addr),
    .o_rs2     (rs2_addr),
    .o_rd      (rd_addr),
    .o_value   (value),
    .o_ext_imm (extended_imm)
  );

  // A load in EX whose destination feeds an operand ID reads forces one
  // bubble; the bubble clears r_ex_load_valid so the hazard cannot repeat.
  assign w_stall = r_ex_load_valid && (r_ex_load_rd != 5'd0) &&
                   ((w_ctrl.rd_rs1 && (rs1_addr == r_ex_load_rd)) ||
                    (w_ctrl.rd_rs2 && (rs2_addr == r_ex_load_rd)));

  assign w_gate     = r_valid && !w_stall;
  assign beqz       = w_gate && w_ctrl.beqz;
  assign bnez       = w_gate && w_ctrl.bnez;
  assign jump       = w_gate && w_ctrl.jump;
  assign jump_reg   = w_gate && w_ctrl.jump_reg;
  assign mem_read   = w_gate && w_ctrl.mem_read;
  assign mem_write  = w_gate && w_ctrl.mem_write;
  assign reg_write  = w_gate && w_ctrl.reg_write;
  assign pc_stall   = w_stall;
  assign ex_bubble  = w_stall;

  // Controls are already gated, so a stalled or flushed slot never redirects.
  assign w_redirect = jump || (beqz && zero_flag) || (bnez && !zero_flag);

  assign id_valid    = r_valid;
  assign id_instr    = r_instr;
  assign id_pc_plus4 = r_pc_plus4;

  // IF/ID register: hold on stall, squash on redirect, else capture fetch
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
      r_pc_plus4 <= '0;
    end else if (w_stall) begin
      r_valid    <= r_valid;
    end else if (w_redirect) begin
      r_valid    <= 1'b0;
      r_instr    <= NOP_INSTR;
    end else begin
      r_valid    <= 1'b1;
      r_instr    <= if_instr;
      r_pc_plus4 <= if_pc_plus4;
    end
  end

  // Track the load entering EX; a bubble enters EX during a stall
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_ex_load_valid <= 1'b0;
      r_ex_load_rd    <= 5'd0;
    end else if (w_stall) begin
      r_ex_load_valid <= 1'b0;
    end else begin
      r_ex_load_valid <= mem_read;
      r_ex_load_rd    <= rd_addr;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_if_id_decode.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module      : tb_if_id_decode                                        |
// | Description : Directed self-checking bench for if_id_decode.         |
// | Revision    : 1.0 - initial release                                  |
// +----------------------------------------------------------------------+
module tb_if_id_decode;

  localparam logic [31:0] c_ADDI1  = 32'h2001_0005; // ADDI r1,r0,5
  localparam logic [31:0] c_ADD2   = 32'h0021_1020; // ADD  r2,r1,r1
  localparam logic [31:0] c_LW3    = 32'h8C03_0000; // LW   r3,0(r0)
  localparam logic [31:0] c_ADD4   = 32'h0063_2020; // ADD  r4,r3,r3
  localparam logic [31:0] c_BEQZ5  = 32'h10A0_0008; // BEQZ r5,+8
  localparam logic [31:0] c_JALR7  = 32'h4CE0_FFFC; // JALR r7 (imm FFFC)
  localparam logic [31:0] c_ORI    = 32'h3441_FFFC; // ORI  r1,r2,0xFFFC
  localparam logic [31:0] c_LW5    = 32'h8C05_0000; // LW   r5,0(r0)
  localparam logic [31:0] c_BNEZ5  = 32'h14A0_0008; // BNEZ r5,+8

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] if_instr;
  logic [31:0] if_pc_plus4;
  logic        zero_flag;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr;
  logic        beqz, bnez, jump, jump_reg;
  logic [25:0] value;
  logic [31:0] extended_imm;
  logic        mem_read, mem_write, reg_write, pc_stall, ex_bubble;

  int n_pass  = 0;
  int n_total = 0;

  if_id_decode dut (
    .clk          (clk),
    .reset        (reset),
    .if_instr     (if_instr),
    .if_pc_plus4  (if_pc_plus4),
    .zero_flag    (zero_flag),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_pc_plus4  (id_pc_plus4),
    .rs1_addr     (rs1_addr),
    .rs2_addr     (rs2_addr),
    .rd_addr      (rd_addr),
    .beqz         (beqz),
    .bnez         (bnez),
    .jump         (jump),
    .jump_reg     (jump_reg),
    .value        (value),
    .extended_imm (extended_imm),
    .mem_read     (mem_read),
    .mem_write    (mem_write),
    .reg_write    (reg_write),
    .pc_stall     (pc_stall),
    .ex_bubble    (ex_bubble)
  );

  always #5 clk = ~clk;

  // Present a fetch word, take one rising edge, settle 1 time unit
  task automatic step(input logic [31:0] ins, input logic [31:0] pc4);
    if_instr    = ins;
    if_pc_plus4 = pc4;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; zero_flag = 1'b0; if_instr = c_ADDI1; if_pc_plus4 = 32'h4;
    #2;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_valid: got %0h want 0", id_valid); else n_pass++;
    n_total++; if (id_instr !== 32'h0) $display("FAIL rst_instr: got %08h want 00000000", id_instr); else n_pass++;
    n_total++; if (id_pc_plus4 !== 32'h0) $display("FAIL rst_pc4: got %08h want 00000000", id_pc_plus4); else n_pass++;
    n_total++; if ({pc_stall, ex_bubble, reg_write, jump} !== 4'b0) $display("FAIL rst_ctrl: got %b want 0000", {pc_stall, ex_bubble, reg_write, jump}); else n_pass++;
    @(posedge clk); #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_hold_valid: got %0h want 0", id_valid); else n_pass++;
    reset = 1'b0;
    // Drive into a load-use stall, then reset asynchronously mid-stall
    step(c_LW3, 32'h4);
    step(c_ADD4, 32'h8);
    n_total++; if (pc_stall !== 1'b1) $display("FAIL rst_pre_stall: got %0h want 1", pc_stall); else n_pass++;
    #1 reset = 1'b1;
    #1;
    n_total++; if (id_valid !== 1'b0) $display("FAIL rst_async_valid: got %0h want 0", id_valid); else n_pass++;
    n_total++; if (id_instr !== 32'h0) $display("FAIL rst_async_instr: got %08h want 00000000", id_instr); else n_pass++;
    n_total++; if (pc_stall !== 1'b0) $display("FAIL rst_async_stall: got %0h want 0", pc_stall); else n_pass++;
    n_total++; if (ex_bubble !== 1'b0) $display("FAIL rst_async_bubble: got %0h want 0", ex_bubble); else n_pass++;
    #1 reset = 1'b0;
    step(c_ADDI1, 32'h4);
    n_total++; if (id_instr !== c_ADDI1) $display("FAIL rst_first_capture: got %08h want %08h", id_instr, c_ADDI1); else n_pass++;
    n_total++; if (id_valid !== 1'b1) $display("FAIL rst_first_valid: got %0h want 1", id_valid); else n_pass++;
  endtask

  task automatic test_sequential;
    step(c_ADDI1, 32'h10);
    n_total++; if (id_instr !== c_ADDI1) $display("FAIL seq_addi_instr: got %08h want %08h", id_instr, c_ADDI1); else n_pass++;
    n_total++; if (id_pc_plus4 !== 32'h10) $display("FAIL seq_addi_pc4: got %08h want 00000010", id_pc_plus4); else n_pass++;
    n_total++; if (extended_imm !== 32'h5) $display("FAIL seq_addi_imm: got %08h want 00000005", extended_imm); else n_pass++;
    n_total++; if (rd_addr !== 5'd1) $display("FAIL seq_addi_rd: got %0d want 1", rd_addr); else n_pass++;
    n_total++; if ({reg_write, pc_stall} !== 2'b10) $display("FAIL seq_addi_ctrl: got %b want 10", {reg_write, pc_stall}); else n_pass++;
    step(c_ADD2, 32'h14);
    n_total++; if (id_instr !== c_ADD2) $display("FAIL seq_add_instr: got %08h want %08h", id_instr, c_ADD2); else n_pass++;
    n_total++; if ({rs1_addr, rs2_addr, rd_addr} !== {5'd1, 5'd1, 5'd2}) $display("FAIL seq_add_regs: got %0d/%0d/%0d want 1/1/2", rs1_addr, rs2_addr, rd_addr); else n_pass++;
    n_total++; if ({reg_write, pc_stall} !== 2'b10) $display("FAIL seq_add_ctrl: got %b want 10", {reg_write, pc_stall}); else n_pass++;
  endtask

  task automatic test_load_use;
    step(c_LW3, 32'h18);
    n_total++; if ({mem_read, rd_addr, pc_stall} !== {1'b1, 5'd3, 1'b0}) $display("FAIL lu_lw: got mr=%0h rd=%0d st=%0h want 1/3/0", mem_read, rd_addr, pc_stall); else n_pass++;
    step(c_ADD4, 32'h1c);
    n_total++; if (id_instr !== c_ADD4) $display("FAIL lu_add_instr: got %08h want %08h", id_instr, c_ADD4); else n_pass++;
    n_total++; if ({pc_stall, ex_bubble} !== 2'b11) $display("FAIL lu_stall: got %b want 11", {pc_stall, ex_bubble}); else n_pass++;
    n_total++; if (reg_write !== 1'b0) $display("FAIL lu_gated_rw: got %0h want 0", reg_write); else n_pass++;
    step(c_ADDI1, 32'h20);
    n_total++; if (id_instr !== c_ADD4) $display("FAIL lu_hold: got %08h want %08h", id_instr, c_ADD4); else n_pass++;
    n_total++; if ({pc_stall, ex_bubble, reg_write} !== 3'b001) $display("FAIL lu_release: got %b want 001", {pc_stall, ex_bubble, reg_write}); else n_pass++;
    step(c_ADDI1, 32'h20);
    n_total++; if ({id_instr, pc_stall} !== {c_ADDI1, 1'b0}) $display("FAIL lu_advance: got %08h/%0h want %08h/0", id_instr, pc_stall, c_ADDI1); else n_pass++;
  endtask

  task automatic test_branch;
    zero_flag = 1'b1;
    step(c_BEQZ5, 32'h24);
    n_total++; if ({beqz, jump, pc_stall} !== 3'b100) $display("FAIL br_beqz_ctrl: got %b want 100", {beqz, jump, pc_stall}); else n_pass++;
    n_total++; if (extended_imm !== 32'h8) $display("FAIL br_imm: got %08h want 00000008", extended_imm); else n_pass++;
    n_total++; if (reg_write !== 1'b0) $display("FAIL br_rw: got %0h want 0", reg_write); else n_pass++;
    step(c_ADDI1, 32'h28);
    n_total++; if (id_valid !== 1'b0) $display("FAIL br_flush_valid: got %0h want 0", id_valid); else n_pass++;
    n_total++; if (id_instr !== 32'h0) $display("FAIL br_flush_instr: got %08h want 00000000", id_instr); else n_pass++;
    zero_flag = 1'b0;
    step(c_BEQZ5, 32'h2c);
    n_total++; if (beqz !== 1'b1) $display("FAIL br_nt_beqz: got %0h want 1", beqz); else n_pass++;
    step(c_ADD2, 32'h30);
    n_total++; if ({id_valid, id_instr} !== {1'b1, c_ADD2}) $display("FAIL br_nt_noflush: got %0h/%08h want 1/%08h", id_valid, id_instr, c_ADD2); else n_pass++;
  endtask

  task automatic test_jalr_imm;
    step(c_JALR7, 32'h100);
    n_total++; if ({jump, jump_reg} !== 2'b11) $display("FAIL jalr_jump: got %b want 11", {jump, jump_reg}); else n_pass++;
    n_total++; if (rd_addr !== 5'd31) $display("FAIL jalr_rd: got %0d want 31", rd_addr); else n_pass++;
    n_total++; if (rs1_addr !== 5'd7) $display("FAIL jalr_rs1: got %0d want 7", rs1_addr); else n_pass++;
    n_total++; if (id_pc_plus4 !== 32'h100) $display("FAIL jalr_pc4: got %08h want 00000100", id_pc_plus4); else n_pass++;
    n_total++; if (extended_imm !== 32'hFFFF_FFFC) $display("FAIL jalr_sext: got %08h want fffffffc", extended_imm); else n_pass++;
    n_total++; if (value !== 26'h0E0_FFFC) $display("FAIL jalr_value: got %07h want 0e0fffc", value); else n_pass++;
    step(c_ORI, 32'h104);
    n_total++; if ({id_valid, jump} !== 2'b00) $display("FAIL jalr_squash: got %b want 00", {id_valid, jump}); else n_pass++;
    step(c_ORI, 32'h108);
    n_total++; if (extended_imm !== 32'h0000_FFFC) $display("FAIL ori_zext: got %08h want 0000fffc", extended_imm); else n_pass++;
    n_total++; if ({id_valid, reg_write, rd_addr} !== {1'b1, 1'b1, 5'd1}) $display("FAIL ori_ctrl: got %0h/%0h/%0d want 1/1/1", id_valid, reg_write, rd_addr); else n_pass++;
  endtask

  task automatic test_stall_branch;
    zero_flag = 1'b0;
    step(c_LW5, 32'h200);
    n_total++; if (mem_read !== 1'b1) $display("FAIL sb_lw: got %0h want 1", mem_read); else n_pass++;
    step(c_BNEZ5, 32'h204);
    n_total++; if ({pc_stall, ex_bubble, bnez} !== 3'b110) $display("FAIL sb_stall: got %b want 110", {pc_stall, ex_bubble, bnez}); else n_pass++;
    step(c_ADDI1, 32'h208);
    n_total++; if (id_instr !== c_BNEZ5) $display("FAIL sb_hold: got %08h want %08h", id_instr, c_BNEZ5); else n_pass++;
    n_total++; if ({pc_stall, bnez} !== 2'b01) $display("FAIL sb_release: got %b want 01", {pc_stall, bnez}); else n_pass++;
    step(c_ADDI1, 32'h208);
    n_total++; if ({id_valid, id_instr} !== {1'b0, 32'h0}) $display("FAIL sb_flush: got %0h/%08h want 0/00000000", id_valid, id_instr); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_load_use();
    test_branch();
    test_jalr_imm();
    test_stall_branch();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
